layer_control: RTL and testbench

Frame-synchronous configuration controller for the VGA object-priority mux. Two game-side requesters submit layer-enable masks over a req/ack handshake, and one is granted per cycle by round-robin arbitration. Accepted masks are held in a shadow register and committed only at start of frame, so there is no mid-frame tearing. An optional blink sequencer hides the player layer on alternating frame groups, for example invulnerability after a hit.

---
 rtl/layer_control.sv | 131 +++++++++++++
 tb/tb_layer_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_control.sv
// Frame-synchronous layer-enable controller: round-robin config arbitration, shadow/commit at start of frame.
// Optional player blink sequencer enabled by defining LAYER_CTRL_BLINK_EN.
module layer_control #(
  parameter int unsigned BLINK_FRAMES  = 8,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       cfgReqA,
  input  logic [3:0] cfgMaskA,
  output logic       cfgAckA,
  input  logic       cfgReqB,
  input  logic [3:0] cfgMaskB,
  output logic       cfgAckB,
  input  logic       blinkStart,
  output logic [3:0] layerEn,
  output logic       pendingCfg,
  output logic       blinkActive
);

  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 8;

  logic              favour_a;
  logic              elig_a, elig_b, grant_a, grant_b;
  logic [MASK_W-1:0] shadow, shadow_d, active, active_d;
  logic              pending_d;
  logic              hide_d;

  // A requester with its ack in flight is still holding req; skip it for that cycle.
  always_comb begin
    elig_a  = cfgReqA & ~cfgAckA;
    elig_b  = cfgReqB & ~cfgAckB;
    grant_a = elig_a & (~elig_b | favour_a);
    grant_b = elig_b & ~grant_a;
  end

  // Commit uses the pre-cycle shadow; a same-cycle acceptance stays pending for the next frame.
  always_comb begin
    shadow_d  = shadow;
    active_d  = active;
    pending_d = pendingCfg;
    if (startOfFrame && pendingCfg) begin
      active_d  = shadow;
      pending_d = 1'b0;
    end
    if (grant_a) begin
      shadow_d  = cfgMaskA;
      pending_d = 1'b1;
    end else if (grant_b) begin
      shadow_d  = cfgMaskB;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow     <= 4'b1111;
      active     <= 4'b1111;
      layerEn    <= 4'b1111;
      pendingCfg <= 1'b0;
      cfgAckA    <= 1'b0;
      cfgAckB    <= 1'b0;
      favour_a   <= 1'b1;
    end else begin
      shadow     <= shadow_d;
      active     <= active_d;
      layerEn    <= active_d & {3'b111, ~hide_d};
      pendingCfg <= pending_d;
      cfgAckA    <= grant_a;
      cfgAckB    <= grant_b;
      if (grant_a)      favour_a <= 1'b0;
      else if (grant_b) favour_a <= 1'b1;
    end
  end

`ifdef LAYER_CTRL_BLINK_EN
  typedef enum logic [1:0] {IDLE, HIDE, SHOW} blink_state_t;

  blink_state_t     state, state_d;
  logic [CNT_W-1:0] frame_cnt, frame_d, toggle_cnt, toggle_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      toggle_cnt  <= '0;
      blinkActive <= 1'b0;
    end else begin
      state       <= state_d;
      frame_cnt   <= frame_d;
      toggle_cnt  <= toggle_d;
      blinkActive <= (state_d != IDLE);
    end
  end

  // Restart has priority over frame counting.
  always_comb begin
    state_d  = state;
    frame_d  = frame_cnt;
    toggle_d = toggle_cnt;
    if (blinkStart) begin
      state_d  = HIDE;
      frame_d  = '0;
      toggle_d = '0;
    end else if ((state != IDLE) && startOfFrame) begin
      if (frame_cnt + CNT_W'(1) == CNT_W'(BLINK_FRAMES)) begin
        frame_d  = '0;
        toggle_d = toggle_cnt + CNT_W'(1);
        if (toggle_d == CNT_W'(BLINK_TOGGLES)) begin
          state_d  = IDLE;
          toggle_d = '0;
        end else begin
          state_d = (state == HIDE) ? SHOW : HIDE;
        end
      end else begin
        frame_d = frame_cnt + CNT_W'(1);
      end
    end
    hide_d = (state_d == HIDE);
  end
`else
  logic [CNT_W:0] unused_blink;

  assign unused_blink = {blinkStart, CNT_W'(BLINK_FRAMES ^ BLINK_TOGGLES)};
  assign hide_d       = 1'b0;
  assign blinkActive  = 1'b0;
`endif

endmodule

// File: tb/tb_layer_control.sv
// Directed self-checking bench for layer_control (blink checks follow LAYER_CTRL_BLINK_EN).
module tb_layer_control;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       cfgReqA, cfgReqB;
  logic [3:0] cfgMaskA, cfgMaskB;
  logic       cfgAckA, cfgAckB;
  logic       blinkStart;
  logic [3:0] layerEn;
  logic       pendingCfg;
  logic       blinkActive;

  int errors = 0;
  int checks = 0;

  layer_control #(.BLINK_FRAMES(2), .BLINK_TOGGLES(4)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .cfgReqA(cfgReqA), .cfgMaskA(cfgMaskA), .cfgAckA(cfgAckA),
    .cfgReqB(cfgReqB), .cfgMaskB(cfgMaskB), .cfgAckB(cfgAckB),
    .blinkStart(blinkStart), .layerEn(layerEn),
    .pendingCfg(pendingCfg), .blinkActive(blinkActive)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_layerEn"}, layerEn, 4'b1111);
    check({tag, "_pending"}, {3'b0, pendingCfg}, 4'b0);
    check({tag, "_acks"}, {2'b0, cfgAckA, cfgAckB}, 4'b0);
    check({tag, "_blinkActive"}, {3'b0, blinkActive}, 4'b0);
  endtask

  task automatic apply_reset();
    resetN = 1'b0;
    #3;
    tick();
    resetN = 1'b1;
  endtask

  // Eight frames of a FRAMES=2/TOGGLES=4 blink; bit0 after SOF k is 0,1,1,0,0,1,1,1.
  task automatic run_blink_seq(input string tag, input logic [2:0] upper);
    logic [7:0] patt;
    patt = 8'b1110_0110;
    for (int k = 0; k < 8; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check($sformatf("%s_sof%0d_layerEn", tag, k + 1), layerEn, {upper, patt[k]});
      check($sformatf("%s_sof%0d_active", tag, k + 1), {3'b0, blinkActive}, {3'b0, k < 7});
      tick();
      tick();
    end
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; blinkStart = 1'b0;
    cfgReqA = 1'b0; cfgReqB = 1'b0; cfgMaskA = 4'b0; cfgMaskB = 4'b0;
    #12;
    check_reset_vals("reset");
    tick();
    resetN = 1'b1;
    tick();

    // Single A request mid-frame
    cfgReqA = 1'b1; cfgMaskA = 4'b1011;
    tick();
    check("t1_ackA", {3'b0, cfgAckA}, 4'b1);
    check("t1_pending", {3'b0, pendingCfg}, 4'b1);
    check("t1_layerEn_hold", layerEn, 4'b1111);
    cfgReqA = 1'b0;
    tick();
    check("t1_ackA_one_cycle", {3'b0, cfgAckA}, 4'b0);
    check("t1_layerEn_hold2", layerEn, 4'b1111);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("t1_commit", layerEn, 4'b1011);
    check("t1_pending_clr", {3'b0, pendingCfg}, 4'b0);

    // Simultaneous A and B after reset: A first, B next, last wins
    apply_reset();
    check_reset_vals("reset2");
    cfgReqA = 1'b1; cfgMaskA = 4'b0111;
    cfgReqB = 1'b1; cfgMaskB = 4'b1110;
    tick();
    check("t2_acks_first", {2'b0, cfgAckA, cfgAckB}, 4'b0010);
    cfgReqA = 1'b0;
    tick();
    check("t2_acks_second", {2'b0, cfgAckA, cfgAckB}, 4'b0001);
    cfgReqB = 1'b0;
    tick();
    check("t2_acks_idle", {2'b0, cfgAckA, cfgAckB}, 4'b0000);
    check("t2_layerEn_hold", layerEn, 4'b1111);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("t2_commit_last_wins", layerEn, 4'b1110);

    // Acceptance coinciding with startOfFrame while 1111 is pending
    cfgReqA = 1'b1; cfgMaskA = 4'b1111;
    tick();
    cfgReqA = 1'b0;
    tick();
    cfgReqB = 1'b1; cfgMaskB = 4'b0101; startOfFrame = 1'b1;
    tick();
    cfgReqB = 1'b0; startOfFrame = 1'b0;
    check("t3_ackB", {3'b0, cfgAckB}, 4'b1);
    check("t3_commit_old_shadow", layerEn, 4'b1111);
    check("t3_pending_kept", {3'b0, pendingCfg}, 4'b1);
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("t3_commit_new", layerEn, 4'b0101);
    check("t3_pending_clr", {3'b0, pendingCfg}, 4'b0);
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("t3_sof_no_pending", layerEn, 4'b0101);

    // Last grant was B, so a tie goes to A
    cfgReqA = 1'b1; cfgReqB = 1'b1; cfgMaskA = 4'b0101; cfgMaskB = 4'b0101;
    tick();
    check("rr_tie_after_b", {2'b0, cfgAckA, cfgAckB}, 4'b0010);
    cfgReqA = 1'b0;
    tick();
    check("rr_b_follows", {2'b0, cfgAckA, cfgAckB}, 4'b0001);
    cfgReqB = 1'b0;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("rr_commit", layerEn, 4'b0101);
    tick();

`ifdef LAYER_CTRL_BLINK_EN
    // Full blink sequence
    blinkStart = 1'b1;
    tick();
    blinkStart = 1'b0;
    check("b1_start_layerEn", layerEn, 4'b0100);
    check("b1_start_active", {3'b0, blinkActive}, 4'b1);
    tick();
    run_blink_seq("b1", 3'b010);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("b1_steady", layerEn, 4'b0101);

    // Restart during SHOW replays the whole sequence
    blinkStart = 1'b1;
    tick();
    blinkStart = 1'b0;
    for (int k = 0; k < 2; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
    check("b2_in_show", layerEn, 4'b0101);
    blinkStart = 1'b1;
    tick();
    blinkStart = 1'b0;
    check("b2_restart_hide", layerEn, 4'b0100);
    check("b2_restart_active", {3'b0, blinkActive}, 4'b1);
    tick();
    run_blink_seq("b2", 3'b010);

    // Restart coinciding with startOfFrame wins over the HIDE->SHOW flip
    blinkStart = 1'b1;
    tick();
    blinkStart = 1'b0;
    startOfFrame = 1'b1;
    tick();
    check("b3_sof1", layerEn, 4'b0100);
    blinkStart = 1'b1;
    tick();
    blinkStart = 1'b0; startOfFrame = 1'b0;
    check("b3_restart_wins", layerEn, 4'b0100);
    startOfFrame = 1'b1;
    tick();
    check("b3_frame1_after_restart", layerEn, 4'b0100);
    tick();
    startOfFrame = 1'b0;
    check("b3_show_after_restart", layerEn, 4'b0101);
`else
    blinkStart = 1'b1;
    tick();
    blinkStart = 1'b0;
    check("nb_blink_ignored", layerEn, 4'b0101);
    check("nb_active_tied", {3'b0, blinkActive}, 4'b0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("nb_sof_unchanged", layerEn, 4'b0101);
`endif

    // Async reset mid-blink with a pending mask
    blinkStart = 1'b1;
    tick();
    blinkStart = 1'b0;
    cfgReqA = 1'b1; cfgMaskA = 4'b1000;
    tick();
    cfgReqA = 1'b0;
    check("r_pending_before", {3'b0, pendingCfg}, 4'b1);
    #3;
    resetN = 1'b0;
    #1;
    check_reset_vals("async_reset");
    tick();
    resetN = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("r_pending_discarded", layerEn, 4'b1111);
    check("r_active_after", {3'b0, blinkActive}, 4'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
